// File: rtl/rx_scheduler.sv
// Serial-receive scheduler: detects a start bit on rx and emits per-cycle
// commands (start/sample/stop) plus the matrix cell each frame is written to.
module rx_scheduler #(
    parameter int W   = 8,
    parameter int DIV = 3,
    parameter int PAR = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] action,
    output logic       row,
    output logic [0:1] col,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int          HALF      = (DIV / 2 < 1) ? 1 : DIV / 2;
    localparam logic [7:0]  LAST_CYC  = 8'(DIV - 1);
    localparam logic [7:0]  HALF_LAST = 8'(HALF - 1);
    localparam logic [4:0]  LAST_BIT  = 5'(W - 1);
    localparam bit          HAS_PAR   = (PAR != 0);

    localparam logic [3:0]  ACT_NONE  = 4'd0;
    localparam logic [3:0]  ACT_START = 4'd1;
    localparam logic [3:0]  ACT_BIT   = 4'd2;
    localparam logic [3:0]  ACT_STOP  = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [4:0] r_bit;
    logic       r_rx_meta;
    logic       r_rx_s;
    logic       r_rx_d;
    logic [1:0] r_sync_vld;
    logic       r_armed;

    // Synchronizer resets to idle-high; r_armed blocks the fake falling edge
    // that would appear if rx is already low when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_d     <= 1'b1;
            r_sync_vld <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all flops in a
            // chain sample their old inputs on the same edge.
            r_rx_meta  <= rx;
            r_rx_s     <= r_rx_meta;
            r_rx_d     <= r_rx_s;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_armed    <= r_armed | (r_sync_vld[1] & r_rx_s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_bit      <= 5'd0;
            action     <= ACT_NONE;
            row        <= 1'b0;
            col        <= 2'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            action     <= ACT_NONE;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (en && r_armed && r_rx_d && !r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= 8'd0;
                        r_bit   <= 5'd0;
                        busy    <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= 8'd0;
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                            r_bit   <= 5'd0;
                            action  <= ACT_START;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_DATA: begin
                    if (r_cnt == LAST_CYC) begin
                        r_cnt  <= 8'd0;
                        action <= ACT_BIT;
                        if (r_bit == LAST_BIT) begin
                            r_bit   <= 5'd0;
                            r_state <= HAS_PAR ? S_PARITY : S_STOP;
                        end else begin
                            r_bit <= r_bit + 5'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_PARITY: begin
                    if (r_cnt == LAST_CYC) begin
                        r_cnt   <= 8'd0;
                        action  <= ACT_BIT;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_STOP: begin
                    if (r_cnt == LAST_CYC) begin
                        r_cnt <= 8'd0;
                        if (r_rx_s) begin
                            action       <= ACT_STOP;
                            frame_done   <= 1'b1;
                            {row, col}   <= 3'({row, col} + 3'd1);
                            r_state      <= S_IDLE;
                            busy         <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_WAIT_HIGH: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                    r_bit   <= 5'd0;
                    busy    <= 1'b0;
                end
            endcase

            // NOTE: placed after the case so this later non-blocking write
            // overrides a pointer advance on the same edge.
            if (clr) begin
                row <= 1'b0;
                col <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_rx_scheduler.sv
// Randomized bench for rx_scheduler: a frame-level model predicts command
// counts, strobe spacing and the cell pointer for two parameterisations.
module tb_rx_scheduler;

    localparam int W    = 8;
    localparam int DIV0 = 4;
    localparam int DIV1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n  [2];
    logic       rx     [2];
    logic       en     [2];
    logic       clr    [2];
    logic [3:0] act    [2];
    logic       row_o  [2];
    logic [1:0] col_o  [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic       err_o  [2];

    rx_scheduler #(.W(W), .DIV(DIV0), .PAR(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .rx(rx[0]), .en(en[0]), .clr(clr[0]),
        .action(act[0]), .row(row_o[0]), .col(col_o[0]), .busy(busy_o[0]),
        .frame_done(done_o[0]), .frame_err(err_o[0])
    );

    rx_scheduler #(.W(W), .DIV(DIV1), .PAR(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .rx(rx[1]), .en(en[1]), .clr(clr[1]),
        .action(act[1]), .row(row_o[1]), .col(col_o[1]), .busy(busy_o[1]),
        .frame_done(done_o[1]), .frame_err(err_o[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    int div_of [2] = '{DIV0, DIV1};
    int par_of [2] = '{0, 1};
    int exp_idx [2];

    int cyc [2], last [2], n1 [2], n2 [2], n3 [2], nd [2], ne [2];
    int nbusy [2], ngap [2], nchg [2], nbad [2];
    logic [2:0] prev_ptr [2];

    // Monitor samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst_n[i]) begin
                logic [2:0] ptr;
                cyc[i]++;
                case (act[i])
                    4'd0: ;
                    4'd1: begin n1[i]++; last[i] = cyc[i]; end
                    4'd2: begin
                        n2[i]++;
                        if (cyc[i] - last[i] != div_of[i]) ngap[i]++;
                        last[i] = cyc[i];
                    end
                    4'd3: begin
                        n3[i]++;
                        if (cyc[i] - last[i] != div_of[i]) ngap[i]++;
                    end
                    default: nbad[i]++;
                endcase
                if (done_o[i] != (act[i] == 4'd3)) nbad[i]++;
                if (done_o[i]) nd[i]++;
                if (err_o[i]) ne[i]++;
                if (busy_o[i]) nbusy[i]++;
                ptr = {row_o[i], col_o[i]};
                if (ptr != prev_ptr[i] && !done_o[i]) nchg[i]++;
                prev_ptr[i] = ptr;
            end
        end
    end

    task automatic clear_mon(input int id);
        cyc[id] = 0; last[id] = -1000; n1[id] = 0; n2[id] = 0; n3[id] = 0;
        nd[id] = 0; ne[id] = 0; nbusy[id] = 0; ngap[id] = 0; nchg[id] = 0; nbad[id] = 0;
        prev_ptr[id] = {row_o[id], col_o[id]};
    endtask

    task automatic send_bit(input int id, input logic v);
        rx[id] = v;
        repeat (div_of[id]) @(negedge clk);
    endtask

    task automatic wait_idle(input int id);
        for (int c = 0; c < 40 && busy_o[id]; c++) @(negedge clk);
        check($sformatf("busy_end%0d", id), busy_o[id], 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_ptr(input int id, input string tag);
        check({tag, "_row"}, row_o[id], exp_idx[id] >> 2);
        check({tag, "_col"}, col_o[id], exp_idx[id] & 3);
    endtask

    // One complete serial frame; model is the frame-level outcome.
    task automatic frame(input int id, input logic [15:0] data, input bit stop,
                         input bit do_clr, input bit en_start, input bit en_drop);
        int exp_bits;
        bit started;
        started  = en_start;
        exp_bits = W + par_of[id];
        clear_mon(id);
        en[id] = en_start;
        send_bit(id, 1'b0);
        if (en_drop) en[id] = 1'b0;
        for (int b = 0; b < W; b++) send_bit(id, data[b]);
        if (par_of[id] != 0) send_bit(id, ^data[W-1:0]);
        if (do_clr) clr[id] = 1'b1;
        send_bit(id, stop);
        if (!stop) begin
            repeat (20) @(negedge clk);
            check("busy_hold", busy_o[id], started ? 1 : 0);
        end
        if (do_clr) begin
            repeat (2) @(negedge clk);
            clr[id] = 1'b0;
        end
        rx[id] = 1'b1;
        wait_idle(id);
        en[id] = 1'b1;

        if (started && stop) exp_idx[id] = (exp_idx[id] + 1) % 8;
        if (do_clr) exp_idx[id] = 0;

        check("n_start",  n1[id], started ? 1 : 0);
        check("n_sample", n2[id], started ? exp_bits : 0);
        check("n_stop",   n3[id], (started && stop) ? 1 : 0);
        check("n_done",   nd[id], (started && stop) ? 1 : 0);
        check("n_err",    ne[id], (started && !stop) ? 1 : 0);
        check("spacing",  ngap[id], 0);
        check("bad_code", nbad[id], 0);
        if (!do_clr) check("ptr_stable", nchg[id], 0);
        check_ptr(id, "frame");
    endtask

    task automatic glitch(input int id);
        clear_mon(id);
        rx[id] = 1'b0;
        @(negedge clk);
        rx[id] = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_act", n1[id] + n2[id] + n3[id] + nd[id] + ne[id], 0);
        check("glitch_busy_seen", nbusy[id] > 0, 1);
        check("glitch_busy_end", busy_o[id], 0);
        check_ptr(id, "glitch");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int kind;
        int cnt;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; rx[i] = 1'b1; en[i] = 1'b1; clr[i] = 1'b0; exp_idx[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_outs%0d", i),
                  {act[i], row_o[i], col_o[i], busy_o[i], done_o[i], err_o[i]}, 0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        repeat (6) @(negedge clk);

        // First frame 0xA5, then eight more to walk the whole pointer matrix.
        frame(0, 16'h00A5, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 8; f++)
            frame(0, 16'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
        frame(0, 16'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);

        glitch(0);
        frame(0, 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        frame(0, 16'($urandom), 1'b1, 1'b0, 1'b1, 1'b1);
        frame(0, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0: glitch(0);
                1: frame(0, 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
                2: frame(0, 16'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
                3: frame(0, 16'($urandom), 1'b1, 1'b0, 1'b1, 1'b1);
                4: frame(0, 16'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);
                default: frame(0, 16'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
            endcase
        end

        // Parity variant, then reset at the fifth sample strobe.
        frame(1, 16'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
        rx[1] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 5; c++) begin
            @(negedge clk);
            if (act[1] == 4'd2) cnt++;
        end
        check("rst_wait_strobe5", cnt, 5);
        rst_n[1] = 1'b0;
        #1;
        check("rst_outs_mid", {act[1], row_o[1], col_o[1], busy_o[1], done_o[1], err_o[1]}, 0);
        exp_idx[1] = 0;
        repeat (3) @(negedge clk);
        rst_n[1] = 1'b1;
        clear_mon(1);
        repeat (12) @(negedge clk);
        rx[1] = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_act", n1[1] + n2[1] + n3[1] + nd[1] + ne[1], 0);
        check("post_rst_busy", nbusy[1], 0);
        check_ptr(1, "post_rst");
        frame(1, 16'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
        frame(1, 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
